// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths and the skid-buffer state type used by the
// register slice and its sub-module.
package axil_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int RESP_W = 2;

  // Occupancy of one two-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,  // nothing held
    SKID_ONE   = 2'd1,  // output register valid
    SKID_TWO   = 2'd2   // output and skid registers valid
  } skid_state_e;

  // Write-data beat carried through one slice as a single payload word.
  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
  } w_beat_t;

  // Read-data beat carried through one slice as a single payload word.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
  } r_beat_t;

endpackage

// File: rtl/axil_interface.sv
// AXI-Lite bundle (AW, W, B, AR, R). The master modport drives requests
// and accepts responses; the slave modport is its mirror image.
interface axil_interface;
  import axil_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_skid_buffer.sv
// Two-entry skid buffer for one valid/ready channel. Both the upstream
// ready and the downstream valid/payload come straight from flops, so the
// slice fully breaks timing in both directions at 1 beat/cycle.
module axil_skid_buffer
  import axil_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             axil_clk,
  input  logic             axil_rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  skid_state_e      r_state;
  logic             r_s_ready;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_in_hs;
  logic w_out_hs;

  assign w_in_hs  = s_valid & r_s_ready;
  assign w_out_hs = (r_state != SKID_EMPTY) & m_ready;

  // Occupancy FSM, payload registers and registered upstream ready.
  // r_s_ready resets low and is first loaded on the edge after reset
  // release, so it doubles as the registered init flag.
  always_ff @(posedge axil_clk or negedge axil_rstn) begin
    if (!axil_rstn) begin
      r_state     <= SKID_EMPTY;
      r_s_ready   <= 1'b0;
      // NOTE: payload registers are reset too, so nothing stale can ever be
      // presented; async reset also discards held beats immediately.
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge state and the skid->output move happens in one edge.
      case (r_state)
        SKID_EMPTY: begin
          if (w_in_hs) begin
            r_state    <= SKID_ONE;
            r_out_data <= s_data;
          end
        end
        SKID_ONE: begin
          if (w_in_hs && !w_out_hs) begin
            r_state     <= SKID_TWO;
            r_skid_data <= s_data;
          end else if (w_in_hs) begin
            r_out_data <= s_data;
          end else if (w_out_hs) begin
            r_state <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_out_hs) begin
            r_state    <= SKID_ONE;
            r_out_data <= r_skid_data;
          end
        end
        default: r_state <= SKID_EMPTY;
      endcase
      // Ready for the next cycle is low exactly when the next state is TWO.
      r_s_ready <= !(((r_state == SKID_ONE) && w_in_hs && !w_out_hs) ||
                     ((r_state == SKID_TWO) && !w_out_hs));
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = (r_state != SKID_EMPTY);
  assign m_data  = r_out_data;

endmodule

// File: rtl/axil_register_slice.sv
// AXI-Lite register slice: five independent channel slices (AW, W, AR
// forward; B, R reverse). Each direction is either a skid buffer or plain
// wires, selected by REG_FWD / REG_REV. Channels never interact, so any
// AW/W skew passes through unchanged.
module axil_register_slice
  import axil_pkg::*;
#(
  parameter int REG_FWD = 1,
  parameter int REG_REV = 1
) (
  input  logic           axil_clk,
  input  logic           axil_rstn,
  axil_interface.slave   axil_master,
  axil_interface.master  axil_slave
);

  w_beat_t w_w_in;
  w_beat_t w_w_out;
  r_beat_t w_r_in;
  r_beat_t w_r_out;

  assign w_w_in           = '{strb: axil_master.wstrb, data: axil_master.wdata};
  assign axil_slave.wstrb = w_w_out.strb;
  assign axil_slave.wdata = w_w_out.data;

  assign w_r_in            = '{data: axil_slave.rdata, resp: axil_slave.rresp};
  assign axil_master.rdata = w_r_out.data;
  assign axil_master.rresp = w_r_out.resp;

  if (REG_FWD != 0) begin : g_fwd_reg
    axil_skid_buffer #(.WIDTH(ADDR_W)) u_aw (
      .axil_clk (axil_clk),            .axil_rstn(axil_rstn),
      .s_valid  (axil_master.awvalid), .s_ready  (axil_master.awready),
      .s_data   (axil_master.awaddr),
      .m_valid  (axil_slave.awvalid),  .m_ready  (axil_slave.awready),
      .m_data   (axil_slave.awaddr)
    );
    axil_skid_buffer #(.WIDTH($bits(w_beat_t))) u_w (
      .axil_clk (axil_clk),            .axil_rstn(axil_rstn),
      .s_valid  (axil_master.wvalid),  .s_ready  (axil_master.wready),
      .s_data   (w_w_in),
      .m_valid  (axil_slave.wvalid),   .m_ready  (axil_slave.wready),
      .m_data   (w_w_out)
    );
    axil_skid_buffer #(.WIDTH(ADDR_W)) u_ar (
      .axil_clk (axil_clk),            .axil_rstn(axil_rstn),
      .s_valid  (axil_master.arvalid), .s_ready  (axil_master.arready),
      .s_data   (axil_master.araddr),
      .m_valid  (axil_slave.arvalid),  .m_ready  (axil_slave.arready),
      .m_data   (axil_slave.araddr)
    );
  end else begin : g_fwd_wire
    assign axil_slave.awaddr   = axil_master.awaddr;
    assign axil_slave.awvalid  = axil_master.awvalid;
    assign axil_master.awready = axil_slave.awready;
    assign w_w_out             = w_w_in;
    assign axil_slave.wvalid   = axil_master.wvalid;
    assign axil_master.wready  = axil_slave.wready;
    assign axil_slave.araddr   = axil_master.araddr;
    assign axil_slave.arvalid  = axil_master.arvalid;
    assign axil_master.arready = axil_slave.arready;
  end

  if (REG_REV != 0) begin : g_rev_reg
    axil_skid_buffer #(.WIDTH(RESP_W)) u_b (
      .axil_clk (axil_clk),            .axil_rstn(axil_rstn),
      .s_valid  (axil_slave.bvalid),   .s_ready  (axil_slave.bready),
      .s_data   (axil_slave.bresp),
      .m_valid  (axil_master.bvalid),  .m_ready  (axil_master.bready),
      .m_data   (axil_master.bresp)
    );
    axil_skid_buffer #(.WIDTH($bits(r_beat_t))) u_r (
      .axil_clk (axil_clk),            .axil_rstn(axil_rstn),
      .s_valid  (axil_slave.rvalid),   .s_ready  (axil_slave.rready),
      .s_data   (w_r_in),
      .m_valid  (axil_master.rvalid),  .m_ready  (axil_master.rready),
      .m_data   (w_r_out)
    );
  end else begin : g_rev_wire
    assign axil_master.bresp  = axil_slave.bresp;
    assign axil_master.bvalid = axil_slave.bvalid;
    assign axil_slave.bready  = axil_master.bready;
    assign w_r_out            = w_r_in;
    assign axil_master.rvalid = axil_slave.rvalid;
    assign axil_slave.rready  = axil_master.rready;
  end

endmodule

// File: tb/tb_axil_register_slice.sv
// Bench for axil_register_slice: a registered instance checked against an
// occupancy/FIFO model of each channel, and a bypass instance checked for
// same-cycle equality. Channel index: 0=AW 1=W 2=AR 3=B 4=R.
module tb_axil_register_slice;
  import axil_pkg::*;

  localparam int NCH    = 5;
  localparam int N_RAND = 1000;
  localparam int QD     = 16;

  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus (driven by the main process only).
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] out_ready;
  logic [63:0]    in_data [NCH];

  // Observed DUT signals, flattened per channel.
  logic [NCH-1:0] w_in_ready, w_out_valid, bp_in_ready, bp_out_valid;
  logic [63:0]    w_out_data [NCH];
  logic [63:0]    bp_out_data [NCH];

  int checks;
  int failures;
  int drivers_done;

  axil_interface mi_reg ();
  axil_interface si_reg ();
  axil_interface mi_bp ();
  axil_interface si_bp ();

  axil_register_slice u_dut (
    .axil_clk   (clk),
    .axil_rstn  (rstn),
    .axil_master(mi_reg),
    .axil_slave (si_reg)
  );

  axil_register_slice #(.REG_FWD(0), .REG_REV(0)) u_bp (
    .axil_clk   (clk),
    .axil_rstn  (rstn),
    .axil_master(mi_bp),
    .axil_slave (si_bp)
  );

  // Registered instance wiring.
  assign mi_reg.awvalid = in_valid[0];
  assign mi_reg.awaddr  = in_data[0][ADDR_W-1:0];
  assign mi_reg.wvalid  = in_valid[1];
  assign mi_reg.wdata   = in_data[1][DATA_W-1:0];
  assign mi_reg.wstrb   = in_data[1][DATA_W+STRB_W-1:DATA_W];
  assign mi_reg.arvalid = in_valid[2];
  assign mi_reg.araddr  = in_data[2][ADDR_W-1:0];
  assign si_reg.bvalid  = in_valid[3];
  assign si_reg.bresp   = in_data[3][RESP_W-1:0];
  assign si_reg.rvalid  = in_valid[4];
  assign si_reg.rdata   = in_data[4][DATA_W-1:0];
  assign si_reg.rresp   = in_data[4][DATA_W+RESP_W-1:DATA_W];
  assign si_reg.awready = out_ready[0];
  assign si_reg.wready  = out_ready[1];
  assign si_reg.arready = out_ready[2];
  assign mi_reg.bready  = out_ready[3];
  assign mi_reg.rready  = out_ready[4];
  assign w_in_ready  = {si_reg.rready, si_reg.bready, mi_reg.arready, mi_reg.wready, mi_reg.awready};
  assign w_out_valid = {mi_reg.rvalid, mi_reg.bvalid, si_reg.arvalid, si_reg.wvalid, si_reg.awvalid};
  assign w_out_data[0] = 64'(si_reg.awaddr);
  assign w_out_data[1] = 64'({si_reg.wstrb, si_reg.wdata});
  assign w_out_data[2] = 64'(si_reg.araddr);
  assign w_out_data[3] = 64'(mi_reg.bresp);
  assign w_out_data[4] = 64'({mi_reg.rresp, mi_reg.rdata});

  // Bypass instance wiring (same stimulus).
  assign mi_bp.awvalid = in_valid[0];
  assign mi_bp.awaddr  = in_data[0][ADDR_W-1:0];
  assign mi_bp.wvalid  = in_valid[1];
  assign mi_bp.wdata   = in_data[1][DATA_W-1:0];
  assign mi_bp.wstrb   = in_data[1][DATA_W+STRB_W-1:DATA_W];
  assign mi_bp.arvalid = in_valid[2];
  assign mi_bp.araddr  = in_data[2][ADDR_W-1:0];
  assign si_bp.bvalid  = in_valid[3];
  assign si_bp.bresp   = in_data[3][RESP_W-1:0];
  assign si_bp.rvalid  = in_valid[4];
  assign si_bp.rdata   = in_data[4][DATA_W-1:0];
  assign si_bp.rresp   = in_data[4][DATA_W+RESP_W-1:DATA_W];
  assign si_bp.awready = out_ready[0];
  assign si_bp.wready  = out_ready[1];
  assign si_bp.arready = out_ready[2];
  assign mi_bp.bready  = out_ready[3];
  assign mi_bp.rready  = out_ready[4];
  assign bp_in_ready  = {si_bp.rready, si_bp.bready, mi_bp.arready, mi_bp.wready, mi_bp.awready};
  assign bp_out_valid = {mi_bp.rvalid, mi_bp.bvalid, si_bp.arvalid, si_bp.wvalid, si_bp.awvalid};
  assign bp_out_data[0] = 64'(si_bp.awaddr);
  assign bp_out_data[1] = 64'({si_bp.wstrb, si_bp.wdata});
  assign bp_out_data[2] = 64'(si_bp.araddr);
  assign bp_out_data[3] = 64'(mi_bp.bresp);
  assign bp_out_data[4] = 64'({mi_bp.rresp, mi_bp.rdata});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ch_mask(input int ch);
    case (ch)
      0, 2:    return (64'd1 << ADDR_W) - 64'd1;
      1:       return (64'd1 << (DATA_W + STRB_W)) - 64'd1;
      3:       return (64'd1 << RESP_W) - 64'd1;
      default: return (64'd1 << (DATA_W + RESP_W)) - 64'd1;
    endcase
  endfunction

  // ---------------- behavioural model and compare ----------------
  // Each registered channel is a FIFO of accepted beats: the output shows
  // the oldest beat whenever one is held, and the input accepts while fewer
  // than two are held (from the first edge after reset release onward).
  logic [63:0]    mbuf [NCH][QD];
  int             mhead [NCH];
  int             mcnt [NCH];
  logic [NCH-1:0] prev_v, prev_r;
  logic [63:0]    prev_d [NCH];
  logic           armed_pos;

  always @(posedge clk) armed_pos <= rstn;

  always @(negedge clk) begin
    logic in_hs, out_hs;
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        mcnt[c]  = 0;
        mhead[c] = 0;
      end
      prev_v = '0;
    end
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ch%0d_out_valid", c), 64'(w_out_valid[c]), 64'(mcnt[c] > 0));
      check($sformatf("ch%0d_in_ready", c), 64'(w_in_ready[c]),
            64'(armed_pos && rstn && (mcnt[c] < 2)));
      if (mcnt[c] > 0 && w_out_valid[c])
        check($sformatf("ch%0d_out_data", c), w_out_data[c], mbuf[c][mhead[c]]);
      if (rstn && prev_v[c] && !prev_r[c])
        check($sformatf("ch%0d_hold_data", c), w_out_data[c], prev_d[c]);
      check($sformatf("ch%0d_bypass_data", c), bp_out_data[c], in_data[c]);
      in_hs  = in_valid[c] && w_in_ready[c];
      out_hs = w_out_valid[c] && out_ready[c];
      if (out_hs && mcnt[c] > 0) begin
        mhead[c] = (mhead[c] + 1) % QD;
        mcnt[c]  = mcnt[c] - 1;
      end
      if (in_hs && mcnt[c] < QD) begin
        mbuf[c][(mhead[c] + mcnt[c]) % QD] = in_data[c];
        mcnt[c] = mcnt[c] + 1;
      end
      prev_v[c] = w_out_valid[c];
      prev_r[c] = out_ready[c];
      prev_d[c] = w_out_data[c];
    end
    check("bypass_valid", 64'(bp_out_valid), 64'(in_valid));
    check("bypass_ready", 64'(bp_in_ready), 64'(out_ready));
  end

  // ---------------- stimulus ----------------
  // Present one beat and hold it until accepted; returns 1 time unit after
  // the accepting edge with valid dropped.
  task automatic send_beat(input int ch, input logic [63:0] d);
    int n;
    n = 0;
    in_valid[ch] = 1'b1;
    in_data[ch]  = d & ch_mask(ch);
    @(negedge clk);
    while (!w_in_ready[ch] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check($sformatf("ch%0d_send_timeout", ch), 64'(w_in_ready[ch]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic rand_driver(input int ch);
    for (int n = 0; n < N_RAND; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send_beat(ch, {$urandom, $urandom});
    end
    drivers_done++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks       = 0;
    failures     = 0;
    drivers_done = 0;
    rstn         = 1'b0;
    in_valid     = '0;
    out_ready    = '0;
    for (int c = 0; c < NCH; c++) in_data[c] = '0;

    // Reset state and ready rising one edge after release.
    #1;
    check("rst_out_valid", 64'(w_out_valid), 64'h0);
    check("rst_in_ready", 64'(w_in_ready), 64'h0);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    #1 check("rel_in_ready_before_edge", 64'(w_in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("rel_in_ready", 64'(w_in_ready), 64'h1f);

    // Single write: AW and W together, B back.
    out_ready = '1;
    fork
      send_beat(0, 64'h0000_0010);
      send_beat(1, {28'h0, 4'hf, 32'hdead_beef});
    join
    check("wr_awvalid", 64'(w_out_valid[0]), 64'd1);
    check("wr_awaddr", w_out_data[0], 64'h0000_0010);
    check("wr_wvalid", 64'(w_out_valid[1]), 64'd1);
    check("wr_wdata", w_out_data[1], 64'hf_dead_beef);
    send_beat(3, 64'h0);
    check("wr_bvalid", 64'(w_out_valid[3]), 64'd1);
    check("wr_bresp", w_out_data[3], 64'h0);
    @(posedge clk);
    #1;

    // Back-pressure on AR: ready drops after two beats, then drains in order.
    out_ready[2] = 1'b0;
    send_beat(2, 64'h00);
    send_beat(2, 64'h04);
    check("bp_arready_low", 64'(w_in_ready[2]), 64'd0);
    out_ready[2] = 1'b1;
    fork
      begin
        send_beat(2, 64'h08);
        send_beat(2, 64'h0c);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_ar_valid", 64'(w_out_valid[2]), 64'd1);
          check("bp_ar_addr", w_out_data[2], 64'(i * 4));
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Streaming R: 16 back-to-back beats.
    fork
      begin
        for (int i = 0; i < 16; i++) send_beat(4, 64'(i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!w_out_valid[4] && n < 50) begin
          n++;
          @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
          check("stream_r_valid", 64'(w_out_valid[4]), 64'd1);
          check("stream_r_data", w_out_data[4], 64'(i));
          @(negedge clk);
        end
        check("stream_r_end", 64'(w_out_valid[4]), 64'd0);
      end
    join
    @(posedge clk);
    #1;

    // Random valid/ready on all five channels at once.
    fork
      rand_driver(0);
      rand_driver(1);
      rand_driver(2);
      rand_driver(3);
      rand_driver(4);
      begin
        while (drivers_done < NCH) begin
          @(posedge clk);
          #1;
          out_ready = 5'($urandom);
        end
        out_ready = '1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++)
      check($sformatf("ch%0d_drained", c), 64'(mcnt[c]), 64'd0);

    // Reset while AW holds two beats.
    out_ready = '0;
    send_beat(0, 64'h100);
    send_beat(0, 64'h104);
    check("mid_aw_full", 64'(w_in_ready[0]), 64'd0);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(w_out_valid), 64'h0);
    check("mid_rst_in_ready", 64'(w_in_ready), 64'h0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 64'(w_in_ready), 64'h1f);
    check("mid_rel_out_valid", 64'(w_out_valid), 64'h0);
    out_ready = '1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_stale", 64'(w_out_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
